// File: rtl/sigma_delta_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sigma_delta_pkg
//  Description : Shared constants and helpers for the sigma-delta decimator
//                (CIC order, warm-up length, internal width, offset binary).
//  Revision    : 1.0 - initial release
// ============================================================================
package sigma_delta_pkg;

    // Number of integrator/comb stages in the sinc filter.
    localparam int CIC_ORDER    = 3;

    // Comb steps whose output is still contaminated by the filter start-up.
    localparam int WARMUP_STEPS = 3;

    // Internal two's complement width: CIC gain is R**3 = 2**(3*L), and the
    // signed range +/-2**(3L) needs 3L+2 bits.
    function automatic int sd_cic_width(input int decim_log2);
        return CIC_ORDER * decim_log2 + 2;
    endfunction

    // Signed to excess-2**msbi conversion: flipping the sign bit is all it takes.
    function automatic logic [31:0] sd_signed_to_offset(input logic [31:0] value,
                                                        input int          msbi);
        return value ^ (32'd1 << msbi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_cic_integrator.sv
`default_nettype none
// ============================================================================
//  Module      : sd_cic_integrator
//  Description : One enabled W-bit wrapping accumulator of the CIC cascade.
//  Ports       : clk      - clock
//                reset_n  - asynchronous active-low reset
//                i_en     - accumulate strobe
//                i_addend - value added on each strobe (previous stage output)
//                o_acc    - registered accumulator value
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_cic_integrator #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_en,
    input  logic [W-1:0] i_addend,
    output logic [W-1:0] o_acc
);

    logic [W-1:0] r_acc;

    // Wrap-around is intentional: CIC integrators rely on modular arithmetic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + i_addend;
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/sigma_delta_decimator.sv
`default_nettype none
// ============================================================================
//  Module      : sigma_delta_decimator
//  Description : 1-bit sigma-delta bitstream to PCM through a 3rd-order CIC
//                decimator (decimation R = 2**DECIM_LOG2). Output is offset
//                binary (excess 2**MSBI), matching the DAC input format.
//  Ports       : clk       - clock
//                reset_n   - asynchronous active-low reset
//                in        - bitstream bit, sampled when in_en=1
//                in_en     - bitstream sample strobe
//                out       - decimated sample, MSBI+1 bits, offset binary
//                out_valid - one-cycle strobe qualifying out
//  Revision    : 1.0 - initial release
// ============================================================================
module sigma_delta_decimator
    import sigma_delta_pkg::*;
#(
    parameter int   MSBI       = 15,
    parameter int   DECIM_LOG2 = 6,
    parameter logic INV        = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in,
    input  logic          in_en,
    output logic [MSBI:0] out,
    output logic          out_valid
);

    localparam int W     = sd_cic_width(DECIM_LOG2);
    localparam int SHIFT = CIC_ORDER * DECIM_LOG2 - MSBI;

    localparam logic [DECIM_LOG2-1:0] c_CNT_LAST  = {DECIM_LOG2{1'b1}};
    localparam logic [1:0]            c_WARM_DONE = 2'(WARMUP_STEPS);
    localparam logic [W-1:0]          c_POS_FULL  = W'(1) << MSBI;
    localparam logic [MSBI:0]         c_POS_MAX   = {1'b0, {MSBI{1'b1}}};
    localparam logic [MSBI:0]         c_MIDSCALE  = (MSBI+1)'(sd_signed_to_offset(32'd0, MSBI));

    generate
        if ((CIC_ORDER * DECIM_LOG2 < MSBI) || (DECIM_LOG2 < 1) || (DECIM_LOG2 > 8)) begin : g_badParams
            $error("sigma_delta_decimator: illegal MSBI/DECIM_LOG2 combination");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Input mapping: bit 1 -> +1, bit 0 -> -1, sign-extended to W bits.
    // ------------------------------------------------------------------
    logic         w_bit;
    logic [W-1:0] w_integ [0:CIC_ORDER];

    assign w_bit      = in ^ INV;
    assign w_integ[0] = w_bit ? W'(1) : {W{1'b1}};

    // Each stage adds the previous stage's registered value, so all three
    // update in parallel from their old values.
    generate
        for (genvar k = 1; k <= CIC_ORDER; k++) begin : g_integrator
            sd_cic_integrator #(
                .W        (W)
            ) u_integrator (
                .clk      (clk),
                .reset_n  (reset_n),
                .i_en     (in_en),
                .i_addend (w_integ[k-1]),
                .o_acc    (w_integ[k])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Decimation counter; the comb step runs the cycle after the wrap so
    // that it sees I3 including the bit sampled at the wrapping edge.
    // ------------------------------------------------------------------
    logic [DECIM_LOG2-1:0] r_cnt;
    logic                  r_decPending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt        <= '0;
            r_decPending <= 1'b0;
        end else begin
            r_decPending <= in_en && (r_cnt == c_CNT_LAST);
            if (in_en) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Comb step (single shared step, all three differences in one cycle).
    // ------------------------------------------------------------------
    logic [W-1:0] r_d1, r_d2, r_d3;
    logic [W-1:0] w_c1, w_c2, w_c3;
    logic [W-1:0] w_scaled;
    logic [MSBI:0] w_sat;

    assign w_c1 = w_integ[CIC_ORDER] - r_d1;
    assign w_c2 = w_c1 - r_d2;
    assign w_c3 = w_c2 - r_d3;

    assign w_scaled = W'($signed(w_c3) >>> SHIFT);

    // Full-scale positive input yields exactly +2**MSBI, one past the top code.
    assign w_sat = (w_scaled == c_POS_FULL) ? c_POS_MAX : w_scaled[MSBI:0];

    logic [1:0]    r_warm;
    logic [MSBI:0] r_out;
    logic          r_outValid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d1       <= '0;
            r_d2       <= '0;
            r_d3       <= '0;
            r_warm     <= '0;
            r_out      <= c_MIDSCALE;
            r_outValid <= 1'b0;
        end else begin
            r_outValid <= 1'b0;
            if (r_decPending) begin
                r_d1  <= w_integ[CIC_ORDER];
                r_d2  <= w_c1;
                r_d3  <= w_c2;
                r_out <= {~w_sat[MSBI], w_sat[MSBI-1:0]};
                if (r_warm == c_WARM_DONE) begin
                    r_outValid <= 1'b1;
                end else begin
                    r_warm <= r_warm + 1'b1;
                end
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_outValid;

endmodule
`default_nettype wire

// File: tb/tb_sigma_delta_decimator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sigma_delta_decimator
//  Description : Self-checking bench for sigma_delta_decimator (defaults,
//                MSBI=15, DECIM_LOG2=6). Table of bitstream patterns plus
//                loopback and mid-stream reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sigma_delta_decimator;

    localparam int R    = 64;
    localparam int WARM = 3;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        inBit   = 1'b0;
    logic        inEn    = 1'b0;
    logic [15:0] out;
    logic        outValid;
    logic        lbIn    = 1'b0;
    logic        lbEn    = 1'b0;
    logic [15:0] lbOut;
    logic        lbValid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sigma_delta_decimator #(
        .MSBI       (15),
        .DECIM_LOG2 (6),
        .INV        (1'b0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in         (inBit),
        .in_en      (inEn),
        .out        (out),
        .out_valid  (outValid)
    );

    sigma_delta_decimator #(
        .MSBI       (15),
        .DECIM_LOG2 (6),
        .INV        (1'b1)
    ) dutLoop (
        .clk        (clk),
        .reset_n    (reset_n),
        .in         (lbIn),
        .in_en      (lbEn),
        .out        (lbOut),
        .out_valid  (lbValid)
    );

    typedef struct {
        int mode;      // 0: all zeros, 1: all ones, 2: alternating 1,0
        int enPeriod;  // in_en asserted one cycle in enPeriod
        int expOut;    // expected value on every valid pulse
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic patternBit(input int mode, input int n);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            default: return (n % 2) == 0;
        endcase
    endfunction

    task automatic applyReset();
        reset_n = 1'b0;
        inEn    = 1'b0;
        inBit   = 1'b0;
        lbEn    = 1'b0;
        lbIn    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out",       int'(out),      'h8000);
        check("reset_out_valid", int'(outValid), 0);
        reset_n = 1'b1;
    endtask

    task automatic runStream(input int mode, input int enPeriod, input int expOut,
                             input int nValid, input bit doRst, input string tag);
        int cyc          = 0;
        int enCount      = 0;
        int seen         = 0;
        int wrapCyc      = -100;
        int wrapNum      = 0;
        int lastValidCyc = 0;
        int maxCyc;
        maxCyc = enPeriod * R * (WARM + 1 + nValid) + 16;
        if (doRst) applyReset();
        while (seen < nValid && cyc < maxCyc) begin
            inEn  = (cyc % enPeriod) == 0;
            inBit = patternBit(mode, enCount);
            if (inEn) begin
                enCount++;
                if (enCount % R == 0) begin
                    wrapCyc = cyc;
                    wrapNum = enCount / R;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (outValid) begin
                check({tag, "_value"},   int'(out),     expOut);
                check({tag, "_latency"}, cyc - wrapCyc, 2);
                if (seen == 0) check({tag, "_first_step"}, wrapNum, WARM + 1);
                else           check({tag, "_spacing"},    cyc - lastValidCyc, enPeriod * R);
                lastValidCyc = cyc;
                seen++;
            end
        end
        check({tag, "_pulses"}, seen, nValid);
        inEn = 1'b0;
    endtask

    // First-order sigma-delta DAC model with inverted output feeding the
    // INV=1 decimator instance.
    task automatic runLoopback(input logic [15:0] code, input int nValid);
        logic [15:0] acc = '0;
        logic [16:0] sum;
        int cyc  = 0;
        int seen = 0;
        int diff;
        applyReset();
        lbEn = 1'b1;
        while (seen < nValid && cyc < R * (WARM + 2 + nValid)) begin
            sum  = {1'b0, acc} + {1'b0, code};
            acc  = sum[15:0];
            lbIn = ~sum[16];
            @(posedge clk);
            #1;
            cyc++;
            if (lbValid) begin
                diff = int'(lbOut) - int'(code);
                check("loopback_within_2lsb", (diff >= -2 && diff <= 2) ? 1 : 0, 1);
                seen++;
            end
        end
        check("loopback_pulses", seen, nValid);
        lbEn = 1'b0;
    endtask

    initial begin
        int cyc;
        vecs[0] = '{mode: 1, enPeriod: 1, expOut: 'hFFFF};
        vecs[1] = '{mode: 0, enPeriod: 1, expOut: 'h0000};
        vecs[2] = '{mode: 2, enPeriod: 1, expOut: 'h8000};
        vecs[3] = '{mode: 1, enPeriod: 4, expOut: 'hFFFF};

        for (int i = 0; i < 4; i++) begin
            runStream(vecs[i].mode, vecs[i].enPeriod, vecs[i].expOut, 3, 1'b1,
                      $sformatf("vec%0d", i));
        end

        runLoopback(16'hC000, 3);

        // Reset while a valid pulse is on the output.
        applyReset();
        inEn  = 1'b1;
        inBit = 1'b1;
        cyc   = 0;
        while (!outValid && cyc < R * (WARM + 3)) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("midreset_saw_valid", int'(outValid), 1);
        reset_n = 1'b0;
        #1;
        check("midreset_out",       int'(out),      'h8000);
        check("midreset_out_valid", int'(outValid), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        runStream(1, 1, 'hFFFF, 2, 1'b0, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sigma_delta_decimator.md
# sigma_delta_decimator

Receive-side counterpart of the sigma-delta DAC modulator: accepts a 1-bit sigma-delta bitstream and recovers PCM samples through a 3rd-order CIC (sinc³) decimation filter. It sits behind a comparator or external modulator input, or in a loopback path fed directly by the DAC's `out` pin. Its output uses the same excess-2**MSBI (offset-binary) format as the DAC input, so a DAC→decimator loopback returns the original code.

## Interface
- MSBI, 15: highest output bit index; output width is MSBI+1.
- DECIM_LOG2, 6: log2 of the decimation ratio R; R = 2**DECIM_LOG2; legal range 1..8.
- INV, 1'b1: when 1, the input bit is inverted before use; matches the DAC INV convention.
- Constraint: 3*DECIM_LOG2 >= MSBI. Elaboration fails otherwise.
- clk  in  1  single clock for the block.
- reset_n  in  1  asynchronous, active-low reset.
- in  in  1  bitstream bit, sampled only when in_en=1.
- in_en  in  1  bitstream sample strobe; may be held high continuously.
- out  out  MSBI+1  decimated sample, excess 2**MSBI.
- out_valid  out  1  one-cycle strobe; out is valid while out_valid=1.

## Operation
- Input mapping: b = in ^ INV; x = +1 if b=1, x = -1 if b=0; 2-bit signed.
- Internal width W = 3*DECIM_LOG2 + 2, two's complement. All integrator and comb arithmetic wraps modulo 2**W, with no saturation inside the filter.
- Integrators update only on in_en, all registered in parallel from old values: I1<=I1+x; I2<=I2+I1; I3<=I3+I2.
- Decimation counter cnt, DECIM_LOG2 bits, increments on in_en. When in_en=1 and cnt=R-1: cnt wraps to 0 and dec_pending is set for exactly one cycle.
- Comb step, in the cycle where dec_pending=1, computed combinationally from current values:
  - c1 = I3 - D1, then D1 <= I3.
  - c2 = c1 - D2, then D2 <= c1.
  - c3 = c2 - D3, then D3 <= c2.
- Scaling: c3 spans [-2**(3L), +2**(3L)], where L = DECIM_LOG2.
  - s = c3 >>> (3L - MSBI), arithmetic shift.
  - If s equals +2**MSBI, saturate to 2**MSBI - 1.
  - out <= s with bit MSBI inverted, giving offset binary.
- Warm-up: a 2-bit warm counter counts comb steps after reset. out_valid stays suppressed for the first 3 comb steps; out still updates during warm-up. out_valid is first asserted on the 4th comb step.
- No back-pressure. A consumer that misses the out_valid strobe loses that sample.

## Timing
- Reset values: I1..I3, D1..D3, cnt, warm and dec_pending = 0; out = 1<<MSBI (midscale); out_valid = 0.
- Latency: if the wrapping in_en is sampled at edge E0, dec_pending is high after E0. out and out_valid are registered at E1, so out_valid is high for exactly one cycle after E1.
- The I3 value used in a comb step includes the bit sampled at E0.
- in_en held high continuously: out_valid fires once every R cycles. Because R >= 2, comb steps never overlap.
- in_en=1 during a dec_pending cycle: the integrators and cnt update normally at the same edge as the comb step. The comb step reads pre-update I3.
- Reset asserted mid-operation clears everything immediately, including a pending comb step; out_valid drops asynchronously. Warm-up restarts after reset is released.
- Integrator overflow/wrap is expected and harmless. Overflow of the comb output cannot occur, by the choice of W.

## Structure
- Package sigma_delta_pkg:
  - sd_cic_width(decim_log2) function returning 3*decim_log2+2.
  - CIC_ORDER = 3.
  - WARMUP_STEPS = 3.
  - Offset-binary conversion helper, shared with DAC-side test code.
- One sub-module, sd_cic_integrator: an enabled W-bit accumulator, instantiated three times in cascade. The combs stay inline because they form a single shared step.

## Test plan
- Defaults, INV=0, in=1 with in_en=1 constantly: after 3 suppressed steps, every out_valid carries out=0xFFFF (saturated), at intervals of 64 cycles.
- Defaults, INV=0, in=0 constantly: every valid out = 0x0000.
- Defaults, INV=0, alternating 1,0 bits: every valid out = 0x8000 exactly.
- Loopback: DAC (MSBI=15, INV=1) driving this block (INV=1) with constant DAC input 0xC000. After settling, out is within ±2 LSB of 0xC000.
- in_en asserted 1 cycle in 4 with in=1: out_valid spacing is 256 cycles; the first valid pulse occurs on the 4th comb step; the latency check is out_valid high exactly 2 cycles after the wrapping in_en cycle.
- reset_n pulsed low mid-stream: out=0x8000 and out_valid=0 immediately; after release, exactly 3 comb steps pass before the next out_valid.
